// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite constants for the interconnect datapath
package ahb_pkg;

  localparam int NUM_PORTS = 5;
  localparam int ADDR_W    = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  localparam logic [3:0] MASTER_NONE = 4'hF;

  // Slave k owns the 256 MB region whose top nibble is SLAVE_BASE[k].
  localparam logic [NUM_PORTS-1:0][3:0] SLAVE_BASE = {4'h4, 4'h3, 4'h2, 4'h1, 4'h0};

endpackage

// File: rtl/ahb_addr_decoder.sv
// rtl/ahb_addr_decoder.sv - top-nibble address decode to one-hot HSEL
module ahb_addr_decoder
  import ahb_pkg::*;
(
  input  logic [ADDR_W-1:0]    addr,
  output logic [NUM_PORTS-1:0] hsel
);

  always_comb begin
    hsel = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (addr[ADDR_W-1 -: 4] == SLAVE_BASE[k]) hsel[k] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_bus_datapath.sv
// rtl/ahb_bus_datapath.sv - 5x5 AHB-Lite interconnect datapath driven by an external HMASTER
module ahb_bus_datapath
  import ahb_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  HMASTER,
  input  logic [31:0] HADDR0, HADDR1, HADDR2, HADDR3, HADDR4,
  input  logic [31:0] HWDATA0, HWDATA1, HWDATA2, HWDATA3, HWDATA4,
  input  logic        HWRITE0, HWRITE1, HWRITE2, HWRITE3, HWRITE4,
  input  logic [1:0]  HTRANS0, HTRANS1, HTRANS2, HTRANS3, HTRANS4,
  input  logic [2:0]  HSIZE0, HSIZE1, HSIZE2, HSIZE3, HSIZE4,
  input  logic [2:0]  HBURST0, HBURST1, HBURST2, HBURST3, HBURST4,
  output logic [31:0] mux_addr_out,
  output logic [31:0] mux_wout,
  output logic        mux_write,
  output logic [1:0]  mux_trans,
  output logic [2:0]  mux_size,
  output logic [2:0]  mux_burst,
  output logic [4:0]  HSEL,
  input  logic [31:0] HRDATA0, HRDATA1, HRDATA2, HRDATA3, HRDATA4,
  input  logic [1:0]  HRESP0, HRESP1, HRESP2, HRESP3, HRESP4,
  input  logic        HREADY0, HREADY1, HREADY2, HREADY3, HREADY4,
  output logic [31:0] rd_mux_out,
  output logic [1:0]  resp_mux_out,
  output logic        mux_ready,
  output logic [31:0] mHRDATA0, mHRDATA1, mHRDATA2, mHRDATA3, mHRDATA4,
  output logic [1:0]  mHRESP0, mHRESP1, mHRESP2, mHRESP3, mHRESP4
);

  logic [ADDR_W-1:0] haddr  [NUM_PORTS];
  logic [ADDR_W-1:0] hwdata [NUM_PORTS];
  logic [ADDR_W-1:0] hrdata [NUM_PORTS];
  logic [ADDR_W-1:0] m_rdata[NUM_PORTS];
  logic [1:0]        htrans [NUM_PORTS];
  logic [1:0]        hresp  [NUM_PORTS];
  logic [1:0]        m_resp [NUM_PORTS];
  logic [2:0]        hsize  [NUM_PORTS];
  logic [2:0]        hburst [NUM_PORTS];
  logic [NUM_PORTS-1:0] hwrite, hready;

  logic [3:0]           dp_master;
  logic [NUM_PORTS-1:0] dp_sel;

  assign haddr  = '{HADDR0, HADDR1, HADDR2, HADDR3, HADDR4};
  assign hwdata = '{HWDATA0, HWDATA1, HWDATA2, HWDATA3, HWDATA4};
  assign hrdata = '{HRDATA0, HRDATA1, HRDATA2, HRDATA3, HRDATA4};
  assign htrans = '{HTRANS0, HTRANS1, HTRANS2, HTRANS3, HTRANS4};
  assign hresp  = '{HRESP0, HRESP1, HRESP2, HRESP3, HRESP4};
  assign hsize  = '{HSIZE0, HSIZE1, HSIZE2, HSIZE3, HSIZE4};
  assign hburst = '{HBURST0, HBURST1, HBURST2, HBURST3, HBURST4};
  assign hwrite = {HWRITE4, HWRITE3, HWRITE2, HWRITE1, HWRITE0};
  assign hready = {HREADY4, HREADY3, HREADY2, HREADY1, HREADY0};

  // Any HMASTER outside 0..4 parks the slave bus on an IDLE transfer at address 0.
  always_comb begin
    mux_addr_out = '0;
    mux_write    = 1'b0;
    mux_trans    = HTRANS_IDLE;
    mux_size     = '0;
    mux_burst    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (HMASTER == 4'(k)) begin
        mux_addr_out = haddr[k];
        mux_write    = hwrite[k];
        mux_trans    = htrans[k];
        mux_size     = hsize[k];
        mux_burst    = hburst[k];
      end
    end
  end

  ahb_addr_decoder u_decoder (
    .addr (mux_addr_out),
    .hsel (HSEL)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dp_master <= MASTER_NONE;
      dp_sel    <= '0;
    end else if (mux_ready) begin
      dp_master <= HMASTER;
      dp_sel    <= HSEL;
    end
  end

  // Data-phase muxes key off the registered owner, so a wait state freezes them.
  always_comb begin
    mux_ready    = 1'b1;
    rd_mux_out   = '0;
    resp_mux_out = HRESP_OKAY;
    mux_wout     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (dp_sel[k]) begin
        mux_ready    = hready[k];
        rd_mux_out   = hrdata[k];
        resp_mux_out = hresp[k];
      end
      if (dp_master == 4'(k)) mux_wout = hwdata[k];
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_PORTS; n++) begin
      m_rdata[n] = (dp_master == 4'(n)) ? rd_mux_out : '0;
      m_resp[n]  = (dp_master == 4'(n)) ? resp_mux_out : HRESP_OKAY;
    end
  end

  assign mHRDATA0 = m_rdata[0];
  assign mHRDATA1 = m_rdata[1];
  assign mHRDATA2 = m_rdata[2];
  assign mHRDATA3 = m_rdata[3];
  assign mHRDATA4 = m_rdata[4];
  assign mHRESP0  = m_resp[0];
  assign mHRESP1  = m_resp[1];
  assign mHRESP2  = m_resp[2];
  assign mHRESP3  = m_resp[3];
  assign mHRESP4  = m_resp[4];

endmodule

// File: tb/tb_ahb_bus_datapath.sv
// tb/tb_ahb_bus_datapath.sv - scoreboard bench for the AHB interconnect datapath
module tb_ahb_bus_datapath;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  HMASTER;
  logic [31:0] haddr  [5];
  logic [31:0] hwdata [5];
  logic [31:0] hrdata [5];
  logic [1:0]  htrans [5];
  logic [1:0]  hresp  [5];
  logic [2:0]  hsize  [5];
  logic [2:0]  hburst [5];
  logic        hwrite [5];
  logic        hready [5];
  logic [31:0] m_hrdata [5];
  logic [1:0]  m_hresp  [5];
  logic [31:0] mux_addr_out, mux_wout, rd_mux_out;
  logic        mux_write, mux_ready;
  logic [1:0]  mux_trans, resp_mux_out;
  logic [2:0]  mux_size, mux_burst;
  logic [4:0]  HSEL;

  typedef struct {
    int          m;
    int          s;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  ahb_bus_datapath dut (
    .CLK(CLK), .RESET(RESET), .HMASTER(HMASTER),
    .HADDR0(haddr[0]), .HADDR1(haddr[1]), .HADDR2(haddr[2]), .HADDR3(haddr[3]), .HADDR4(haddr[4]),
    .HWDATA0(hwdata[0]), .HWDATA1(hwdata[1]), .HWDATA2(hwdata[2]), .HWDATA3(hwdata[3]), .HWDATA4(hwdata[4]),
    .HWRITE0(hwrite[0]), .HWRITE1(hwrite[1]), .HWRITE2(hwrite[2]), .HWRITE3(hwrite[3]), .HWRITE4(hwrite[4]),
    .HTRANS0(htrans[0]), .HTRANS1(htrans[1]), .HTRANS2(htrans[2]), .HTRANS3(htrans[3]), .HTRANS4(htrans[4]),
    .HSIZE0(hsize[0]), .HSIZE1(hsize[1]), .HSIZE2(hsize[2]), .HSIZE3(hsize[3]), .HSIZE4(hsize[4]),
    .HBURST0(hburst[0]), .HBURST1(hburst[1]), .HBURST2(hburst[2]), .HBURST3(hburst[3]), .HBURST4(hburst[4]),
    .mux_addr_out(mux_addr_out), .mux_wout(mux_wout), .mux_write(mux_write), .mux_trans(mux_trans),
    .mux_size(mux_size), .mux_burst(mux_burst), .HSEL(HSEL),
    .HRDATA0(hrdata[0]), .HRDATA1(hrdata[1]), .HRDATA2(hrdata[2]), .HRDATA3(hrdata[3]), .HRDATA4(hrdata[4]),
    .HRESP0(hresp[0]), .HRESP1(hresp[1]), .HRESP2(hresp[2]), .HRESP3(hresp[3]), .HRESP4(hresp[4]),
    .HREADY0(hready[0]), .HREADY1(hready[1]), .HREADY2(hready[2]), .HREADY3(hready[3]), .HREADY4(hready[4]),
    .rd_mux_out(rd_mux_out), .resp_mux_out(resp_mux_out), .mux_ready(mux_ready),
    .mHRDATA0(m_hrdata[0]), .mHRDATA1(m_hrdata[1]), .mHRDATA2(m_hrdata[2]), .mHRDATA3(m_hrdata[3]), .mHRDATA4(m_hrdata[4]),
    .mHRESP0(m_hresp[0]), .mHRESP1(m_hresp[1]), .mHRESP2(m_hresp[2]), .mHRESP3(m_hresp[3]), .mHRESP4(m_hresp[4])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int slave_of(input logic [31:0] addr);
    return (addr[31:28] <= 4'h4) ? int'(addr[31:28]) : -1;
  endfunction

  task automatic addr_phase(input int m, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input logic [1:0] resp);
    exp_t e;
    int   s;
    HMASTER   = 4'(m);
    haddr[m]  = addr;
    hwrite[m] = wr;
    htrans[m] = 2'b10;
    hsize[m]  = 3'b010;
    hburst[m] = 3'(m);
    #1;
    s = slave_of(addr);
    chk($sformatf("addr_m%0d", m), mux_addr_out, addr);
    chk($sformatf("write_m%0d", m), 32'(mux_write), 32'(wr));
    chk($sformatf("trans_m%0d", m), 32'(mux_trans), 32'd2);
    chk($sformatf("size_m%0d", m), 32'(mux_size), 32'd2);
    chk($sformatf("burst_m%0d", m), 32'(mux_burst), 32'(m));
    chk($sformatf("hsel_a%h", addr), 32'(HSEL), (s >= 0) ? (32'd1 << s) : 32'd0);
    e.m = m; e.s = s; e.wdata = wdata; e.rdata = rdata; e.resp = resp;
    sb.push_back(e);
  endtask

  task automatic data_phase(input bit do_pop);
    exp_t        e;
    logic [31:0] er;
    logic [1:0]  ep;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty got=0 exp=1");
      return;
    end
    e = sb[0];
    hwdata[e.m] = e.wdata;
    if (e.s >= 0) begin
      hrdata[e.s] = e.rdata;
      hresp[e.s]  = e.resp;
    end
    #1;
    er = (e.s >= 0) ? e.rdata : 32'd0;
    ep = (e.s >= 0) ? e.resp : 2'b00;
    chk($sformatf("wout_m%0d", e.m), mux_wout, e.wdata);
    chk($sformatf("rdmux_m%0d", e.m), rd_mux_out, er);
    chk($sformatf("respmux_m%0d", e.m), 32'(resp_mux_out), 32'(ep));
    chk($sformatf("ready_m%0d", e.m), 32'(mux_ready), (e.s >= 0) ? 32'(hready[e.s]) : 32'd1);
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("mHRDATA%0d", n), m_hrdata[n], (n == e.m) ? er : 32'd0);
      chk($sformatf("mHRESP%0d", n), 32'(m_hresp[n]), (n == e.m) ? 32'(ep) : 32'd0);
    end
    if (do_pop) void'(sb.pop_front());
  endtask

  task automatic xfer(input int m, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic [1:0] resp);
    addr_phase(m, addr, wr, wdata, rdata, resp);
    tick();
    HMASTER = 4'hF;
    data_phase(1'b1);
  endtask

  initial begin
    RESET   = 1'b1;
    HMASTER = 4'hF;
    for (int k = 0; k < 5; k++) begin
      haddr[k]  = $urandom;
      hwdata[k] = $urandom;
      hrdata[k] = $urandom;
      htrans[k] = 2'b10;
      hresp[k]  = 2'b01;
      hsize[k]  = 3'b010;
      hburst[k] = 3'b001;
      hwrite[k] = 1'b1;
      hready[k] = 1'b1;
    end
    #1;
    chk("rst_wout", mux_wout, 32'd0);
    chk("rst_rdmux", rd_mux_out, 32'd0);
    chk("rst_resp", 32'(resp_mux_out), 32'd0);
    chk("rst_ready", 32'(mux_ready), 32'd1);
    chk("rst_trans", 32'(mux_trans), 32'd0);
    chk("rst_addr", mux_addr_out, 32'd0);
    tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("rst_mHRDATA%0d", n), m_hrdata[n], 32'd0);
      chk($sformatf("rst_mHRESP%0d", n), 32'(m_hresp[n]), 32'd0);
    end
    RESET = 1'b0;
    tick();

    xfer(2, 32'h3000_0010, 1'b1, 32'hDEAD_BEEF, $urandom, 2'b00);
    xfer(4, 32'h4000_0000, 1'b0, $urandom, 32'h1234_5678, 2'b00);
    xfer(0, 32'h9000_0000, 1'b0, $urandom, $urandom, 2'b01);
    xfer(1, 32'h3000_0040, 1'b0, $urandom, $urandom, 2'b01);
    for (int i = 0; i < 8; i++) begin
      xfer(int'($urandom_range(0, 4)), {4'($urandom_range(0, 6)), 28'($urandom)},
           1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 1)));
    end

    HMASTER  = 4'd5;
    #1;
    chk("bad_master_addr", mux_addr_out, 32'd0);
    chk("bad_master_trans", 32'(mux_trans), 32'd0);
    chk("bad_master_write", 32'(mux_write), 32'd0);
    chk("bad_master_hsel", 32'(HSEL), 32'd1);
    HMASTER = 4'hF;
    tick();

    // Slave 1 inserts two wait states while HMASTER moves to 3.
    addr_phase(0, 32'h1000_0000, 1'b0, $urandom, 32'hCAFE_0001, 2'b00);
    tick();
    hready[1] = 1'b0;
    HMASTER   = 4'd3;
    haddr[3]  = 32'h2000_0000;
    data_phase(1'b0);
    tick();
    data_phase(1'b0);
    tick();
    hready[1] = 1'b1;
    data_phase(1'b1);
    addr_phase(3, 32'h0000_0100, 1'b0, $urandom, 32'hBEEF_0003, 2'b00);
    tick();
    HMASTER = 4'hF;
    data_phase(1'b1);

    // Asynchronous reset drops a pending data phase.
    addr_phase(2, 32'h2000_0000, 1'b0, $urandom, $urandom, 2'b01);
    tick();
    HMASTER = 4'hF;
    hrdata[2] = 32'h5555_AAAA;
    hresp[2]  = 2'b01;
    RESET = 1'b1;
    #1;
    void'(sb.pop_front());
    chk("midrst_mHRDATA2", m_hrdata[2], 32'd0);
    chk("midrst_mHRESP2", 32'(m_hresp[2]), 32'd0);
    chk("midrst_rdmux", rd_mux_out, 32'd0);
    chk("midrst_ready", 32'(mux_ready), 32'd1);
    chk("midrst_wout", mux_wout, 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
